basic_loops_ctrl: RTL
=====================

# basic_loops_ctrl

Sequencer that wraps one `basic_loops` HLS core (ap_ctrl_hs block-level protocol, ap_memory array port A).
- Accepts a 16-byte frame on a valid/ready input stream and stores it in an internal 16x8 buffer.
- Serves the buffer to the core's `A` port, starts the core, captures `ap_return` and presents it on a valid/ready result port.
- Has a watchdog.
- Sits between the board-level byte interface and the core, so the SystemC/Verilog co-simulation bench and the FPGA/ASIC top drive only streams.

## Interface
- `TIMEOUT`, 1023: max cycles from start to `core_done` before abort (10-bit watchdog; must be 1..1023).
- `ap_clk` in 1: single clock, rising edge.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `s_data` in 8: input byte.
- `s_valid` in 1: input byte valid.
- `s_ready` out 1: controller accepts byte; transfer on `s_valid & s_ready`.
- `r_data` out 13: captured core result (0 on timeout).
- `r_err` out 1: result is a timeout abort, qualified by `r_valid`.
- `r_valid` out 1: result available.
- `r_ready` in 1: result consumer ready; transfer on `r_valid & r_ready`.
- `core_rst` out 1: active-high reset to core, equals `~ap_rst_n` combinationally.
- `core_start` out 1: to core `ap_start`.
- `core_done` in 1: from core `ap_done`.
- `core_idle` in 1: from core `ap_idle`.
- `core_ready` in 1: from core `ap_ready`.
- `core_A_address0` in 4: core read address.
- `core_A_ce0` in 1: core read enable.
- `core_A_q0` out 8: read data to core.
- `busy` out 1: high in every state except LOAD.

## Operation
- States: IDLE, LOAD, START, WAIT, RESULT, FLUSH.
- Reset state: IDLE. Outputs during reset:
  - `s_ready`, `core_start`, `r_valid` and `r_err` are 0.
  - `r_data` is 0 and `core_A_q0` is 0.
  - `busy` is 1.
  - Buffer contents are undefined.
- IDLE: goes to LOAD unconditionally on the next clock.
- LOAD: `s_ready`=1.
  - Each transfer writes `mem[wptr]` and increments the 4-bit `wptr`.
  - The transfer with `wptr`==15 wraps `wptr` to 0 and goes to START.
  - `s_valid` gaps stall the load without penalty.
- START: `core_start`=1 and the watchdog is cleared.
  - `core_start` holds until a cycle with `core_ready`=1. `core_start` is 0 from the next cycle.
  - Exit on a `core_ready` cycle:
    - If `core_done`=1 in the same cycle: capture result, go to RESULT.
    - Otherwise: go to WAIT.
  - `core_idle` is ignored.
- WAIT: the watchdog increments every cycle.
  - On `core_done`=1: `r_data<=core_return` (13 bits, no truncation), `r_err<=0`, go to RESULT.
  - Else if the watchdog reaches TIMEOUT: `r_data<=0`, `r_err<=1`, go to RESULT.
  - `core_done` wins over a coincident timeout.
  - The watchdog runs only in WAIT. START is bounded by the core's `ap_ready`.
- RESULT: `r_valid`=1; `r_data` and `r_err` are stable until accepted. On `r_valid & r_ready`, go to LOAD.
- FLUSH: not entered from RESULT after a timeout.
  - After a timeout the core may still be running. The next frame's `core_start` is gated: START waits for `core_idle`=1 before asserting `core_start`. This applies only when the last result had `r_err`=1.
  - After `core_idle` is seen, START proceeds normally.
- Buffer read port:
  - Synchronous: on `core_A_ce0`=1, `core_A_q0<=mem[core_A_address0]`. The core sees the data the cycle after the address.
  - When `core_A_ce0`=0, `core_A_q0` holds its value.
  - Reads are valid in any state.
  - Writes occur only in LOAD, so there is no read/write collision.
- Reset mid-operation: asynchronous return to IDLE and all outputs to their reset values. The core is reset simultaneously via `core_rst`. Any partially loaded frame is discarded.

## Timing
- Frame load: at least 16 cycles with `s_valid` held high.
- START entered the cycle after the 16th transfer. `core_start` is registered and asserted the first cycle in START.
- `r_valid` rises the cycle after the `core_done` cycle.
- `s_ready` rises the cycle after the `r_valid & r_ready` handshake.
- Throughput overhead per frame: 16 load cycles, plus the core runtime, plus 2 cycles of controller overhead, plus consumer stall.
- Timeout: `r_valid` rises TIMEOUT+1 cycles after entry to WAIT.

## Test plan
- Normal frame: behavioural core sums A[0..15]; send bytes 1..16 back-to-back → `r_valid` with `r_data`=136 and `r_err`=0; exactly one `core_start` pulse train, dropped after `core_ready`.
- Max values: send 16×0xFF with random `s_valid` gaps → `r_data`=4080; `s_ready` low outside LOAD; verify `core_A_q0` = buffer[addr] one cycle after each `core_A_ce0`.
- Result backpressure: hold `r_ready`=0 for 20 cycles → `r_data` and `r_valid` stable and `s_ready`=0 throughout; release → `s_ready`=1 the next cycle; the second frame 0..15 yields 120.
- Coincident `core_ready` and `core_done` in START: model asserts both together → direct START→RESULT, correct value, no WAIT cycle.
- Timeout with TIMEOUT=8: model never asserts `core_done`, `core_idle`=0 → `r_valid` with `r_err`=1 and `r_data`=0 at 9 cycles after WAIT entry; the next frame's `core_start` is withheld until the model raises `core_idle`.
- Reset mid-WAIT: drop `ap_rst_n` → `core_rst`=1 immediately and outputs at reset values; after release, one IDLE cycle then `s_ready`=1; a fresh frame 1..16 yields 136.

Source files
------------

// File: rtl/basic_loops_ctrl.sv
// Frame sequencer around one basic_loops HLS core: streams a 16-byte frame into a
// local buffer, serves it on the core's A port, runs the core and returns ap_return.
module basic_loops_ctrl #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic        ap_clk,
   input  logic        ap_rst_n,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [12:0] r_data,
   output logic        r_err,
   output logic        r_valid,
   input  logic        r_ready,
   output logic        core_rst,
   output logic        core_start,
   input  logic        core_done,
   input  logic        core_idle,
   input  logic        core_ready,
   input  logic [12:0] core_return,
   input  logic [3:0]  core_A_address0,
   input  logic        core_A_ce0,
   output logic [7:0]  core_A_q0,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESULT, FLUSH} state_t;
   typedef struct packed {
      logic        err;
      logic [12:0] data;
   } res_t;

   localparam logic [9:0] TMO = 10'(TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] mem [16];
   logic [3:0] wptr_q;
   logic [9:0] wdog_q;
   logic       start_q, tmo_q;
   res_t       res_q, res_d;
   logic       s_fire, res_cap, start_set, start_clr;

   assign s_ready    = (state_q == LOAD);
   assign s_fire     = s_ready & s_valid;
   assign busy       = (state_q != LOAD);
   assign r_valid    = (state_q == RESULT);
   assign r_data     = res_q.data;
   assign r_err      = res_q.err;
   assign core_start = start_q;
   assign core_rst   = ~ap_rst_n;

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      res_cap   = 1'b0;
      start_set = 1'b0;
      start_clr = 1'b0;
      case (state_q)
         IDLE: state_d = LOAD;
         LOAD: begin
            if (s_fire && wptr_q == 4'hF) begin
               state_d   = START;
               // after an abort the core may still be busy; hold ap_start until it idles
               start_set = ~tmo_q | core_idle;
            end
         end
         START: begin
            if (!start_q) begin
               start_set = core_idle;
            end else if (core_ready) begin
               start_clr = 1'b1;
               if (core_done) begin
                  res_cap = 1'b1;
                  res_d   = '{err: 1'b0, data: core_return};
                  state_d = RESULT;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (core_done) begin
               res_cap = 1'b1;
               res_d   = '{err: 1'b0, data: core_return};
               state_d = RESULT;
            end else if (wdog_q == TMO) begin
               res_cap = 1'b1;
               res_d   = '{err: 1'b1, data: 13'd0};
               state_d = RESULT;
            end
         end
         RESULT: if (r_ready) state_d = LOAD;
         FLUSH:  state_d = START;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q   <= IDLE;
         wptr_q    <= 4'd0;
         wdog_q    <= 10'd0;
         start_q   <= 1'b0;
         tmo_q     <= 1'b0;
         res_q     <= '0;
         core_A_q0 <= 8'd0;
      end else begin
         state_q <= state_d;
         if (s_fire) wptr_q <= wptr_q + 4'd1;
         wdog_q <= (state_q == WAIT) ? wdog_q + 10'd1 : 10'd0;
         if (start_set)      start_q <= 1'b1;
         else if (start_clr) start_q <= 1'b0;
         if (res_cap)        tmo_q <= res_d.err;
         else if (start_set) tmo_q <= 1'b0;
         if (res_cap) res_q <= res_d;
         if (core_A_ce0) core_A_q0 <= mem[core_A_address0];
      end
   end

   // buffer is deliberately not reset; writes only happen in LOAD
   always_ff @(posedge ap_clk) begin
      if (s_fire) mem[wptr_q] <= s_data;
   end

endmodule
